// File: rtl/z_event_logger.sv
// Edge-timestamping event logger for the Z1/Z2 sequence-detector outputs, buffered in a FWFT FIFO.
// Latency: an edge seen in cycle t appears at the FIFO head (rd_valid=1) in cycle t+1.
// Backpressure: rd_valid/rd_ready read port; a full FIFO with no same-cycle pop drops the event and sets sticky overflow.
//
// Ports:
//   clk, reset (sync, active-low)  : clock and reset
//   clr (LOGGER_CLEAR_EN only)     : sync active-high clear of counts, overflow, FIFO and timestamp
//   Z1, Z2                         : detector outputs, rising edges are logged
//   rd_ready / rd_valid            : read handshake; rd_kind/rd_ts show the head entry (0 when empty)
//   z1_count, z2_count             : saturating rising-edge counters
//   level, overflow                : FIFO occupancy and sticky drop flag
// Optional feature macro: LOGGER_CLEAR_EN adds the clr input.
module z_event_logger #(
  parameter int DEPTH = 4,
  parameter int TS_W  = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
`ifdef LOGGER_CLEAR_EN
  input  logic                     clr,
`endif
  input  logic                     Z1,
  input  logic                     Z2,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [1:0]               rd_kind,
  output logic [TS_W-1:0]          rd_ts,
  output logic [CNT_W-1:0]         z1_count,
  output logic [CNT_W-1:0]         z2_count,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]       LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]       LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]     PTR_ONE  = AW'(1);
  localparam logic [TS_W-1:0]   TS_ONE   = TS_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic [1:0]       r_kind_mem [DEPTH];
  logic [TS_W-1:0]  r_ts_mem   [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic [TS_W-1:0]  r_ts;
  logic [CNT_W-1:0] r_z1_cnt;
  logic [CNT_W-1:0] r_z2_cnt;
  logic             r_z1_q;
  logic             r_z2_q;
  logic             r_overflow;

  logic w_clr;
  logic w_e1;
  logic w_e2;
  logic w_evt;
  logic w_full;
  logic w_pop;
  logic w_push;

`ifdef LOGGER_CLEAR_EN
  assign w_clr = clr;
`else
  assign w_clr = 1'b0;
`endif

  assign w_e1   = Z1 & ~r_z1_q;
  assign w_e2   = Z2 & ~r_z2_q;
  // An event coinciding with clr is discarded outright.
  assign w_evt  = (w_e1 | w_e2) & ~w_clr;
  assign w_full = (r_level == LVL_FULL);
  assign w_pop  = rd_valid & rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push = w_evt & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ts       <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_z1_cnt   <= '0;
      r_z2_cnt   <= '0;
      r_z1_q     <= 1'b0;
      r_z2_q     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      // Edge registers track the inputs even during clr.
      r_z1_q <= Z1;
      r_z2_q <= Z2;
      if (w_clr) begin
        r_ts       <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_level    <= '0;
        r_z1_cnt   <= '0;
        r_z2_cnt   <= '0;
        r_overflow <= 1'b0;
      end else begin
        r_ts <= r_ts + TS_ONE;
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        if (w_push && !w_pop)      r_level <= r_level + LVL_ONE;
        else if (!w_push && w_pop) r_level <= r_level - LVL_ONE;
        if (w_evt && w_full && !w_pop) r_overflow <= 1'b1;
        // Counts include events dropped on overflow.
        if (w_e1 && (r_z1_cnt != '1)) r_z1_cnt <= r_z1_cnt + CNT_ONE;
        if (w_e2 && (r_z2_cnt != '1)) r_z2_cnt <= r_z2_cnt + CNT_ONE;
      end
    end
  end

  // Storage needs no reset: reads are masked by rd_valid.
  always_ff @(posedge clk) begin
    if (reset && w_push) begin
      r_kind_mem[r_wr_ptr] <= {w_e2, w_e1};
      r_ts_mem[r_wr_ptr]   <= r_ts;
    end
  end

  assign rd_valid = (r_level != '0);
  assign rd_kind  = rd_valid ? r_kind_mem[r_rd_ptr] : 2'b00;
  assign rd_ts    = rd_valid ? r_ts_mem[r_rd_ptr] : '0;
  assign z1_count = r_z1_cnt;
  assign z2_count = r_z2_cnt;
  assign level    = r_level;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_z_event_logger.sv
module tb_z_event_logger;

  logic       clk;
  logic       reset;
  logic       clr;
  logic       Z1;
  logic       Z2;
  logic       rd_ready;
  logic       rd_valid;
  logic [1:0] rd_kind;
  logic [7:0] rd_ts;
  logic [7:0] z1_count;
  logic [7:0] z2_count;
  logic [2:0] level;
  logic       overflow;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int wrap_c;

  z_event_logger #(.DEPTH(4), .TS_W(8), .CNT_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef LOGGER_CLEAR_EN
    .clr      (clr),
`endif
    .Z1       (Z1),
    .Z2       (Z2),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_kind  (rd_kind),
    .rd_ts    (rd_ts),
    .z1_count (z1_count),
    .z2_count (z2_count),
    .level    (level),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock; cyc tracks the expected timestamp of the current cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; clr = 1'b0; Z1 = 1'b0; Z2 = 1'b0; rd_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", rd_valid, 0);
    chk("rst_kind", rd_kind, 0);
    chk("rst_ts", rd_ts, 0);
    chk("rst_z1", z1_count, 0);
    chk("rst_z2", z2_count, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);

    // Test 1: Z1 pulse at ts=3
    reset = 1'b1; cyc = 0;
    repeat (3) tick();
    Z1 = 1'b1; tick(); Z1 = 1'b0;
    chk("t1_valid", rd_valid, 1);
    chk("t1_kind", rd_kind, 2'b01);
    chk("t1_ts", rd_ts, 3);
    chk("t1_level", level, 1);
    chk("t1_z1", z1_count, 1);

    // Test 2: Z2 held 4 cycles from ts=5
    tick();
    Z2 = 1'b1; repeat (4) tick(); Z2 = 1'b0;
    chk("t2_level", level, 2);
    chk("t2_z2", z2_count, 1);
    chk("t2_head_ts", rd_ts, 3);

    // Test 3: Z1 and Z2 rise together at ts=10
    tick();
    Z1 = 1'b1; Z2 = 1'b1; tick(); Z1 = 1'b0; Z2 = 1'b0;
    chk("t3_level", level, 3);
    chk("t3_z1", z1_count, 2);
    chk("t3_z2", z2_count, 2);

    // Drain in order, then read on empty
    rd_ready = 1'b1; #1;
    chk("d_kind0", rd_kind, 2'b01); chk("d_ts0", rd_ts, 3); tick();
    chk("d_kind1", rd_kind, 2'b10); chk("d_ts1", rd_ts, 5); tick();
    chk("d_kind2", rd_kind, 2'b11); chk("d_ts2", rd_ts, 10); chk("d_level2", level, 1); tick();
    chk("e_valid", rd_valid, 0); chk("e_kind", rd_kind, 0); chk("e_ts", rd_ts, 0); chk("e_level", level, 0);
    tick();
    chk("e_no_underflow", level, 0);
    chk("e_cyc", cyc, 15);
    rd_ready = 1'b0;

    // Test 4/5: fill with Z1 pulses at ts 15,17,19,21
    repeat (4) begin
      Z1 = 1'b1; tick(); Z1 = 1'b0; tick();
    end
    chk("f_level", level, 4);
    chk("f_ovf", overflow, 0);
    chk("f_head", rd_ts, 15);
    // Full with simultaneous pop and push at ts=23
    Z1 = 1'b1; rd_ready = 1'b1; tick(); Z1 = 1'b0; rd_ready = 1'b0;
    chk("pp_level", level, 4);
    chk("pp_ovf", overflow, 0);
    chk("pp_head", rd_ts, 17);
    chk("pp_z1", z1_count, 7);
    // Full with no pop: drop at ts=25
    tick();
    Z1 = 1'b1; tick(); Z1 = 1'b0;
    chk("ov_level", level, 4);
    chk("ov_flag", overflow, 1);
    chk("ov_z1", z1_count, 8);
    chk("ov_head", rd_ts, 17);
    rd_ready = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      chk("ov_drain_kind", rd_kind, 2'b01);
      chk("ov_drain_ts", rd_ts, 32'(17 + 2 * i));
      tick();
    end
    chk("ov_drain_valid", rd_valid, 0);
    chk("ov_drain_level", level, 0);

    // Counter saturation, with the timestamp wrapping meanwhile
    repeat (300) begin
      Z2 = 1'b1; tick(); Z2 = 1'b0; tick();
    end
    chk("sat_z2", z2_count, 255);
    chk("sat_z1", z1_count, 8);
    chk("sat_level", level, 0);
    chk("sat_ovf", overflow, 1);
    rd_ready = 1'b0;

    // Timestamp after wrap: cycle 630 -> 630 mod 256 = 118
    chk("wrap_cyc", cyc, 630);
    wrap_c = cyc;
    Z1 = 1'b1; tick(); Z1 = 1'b0;
    chk("wrap_ts", rd_ts, 118);
    chk("wrap_ts_model", rd_ts, 32'(wrap_c % 256));
    chk("wrap_z1", z1_count, 9);
    tick();
    Z1 = 1'b1; tick(); Z1 = 1'b0; tick();
    Z1 = 1'b1; tick(); Z1 = 1'b0;
    chk("r_level3", level, 3);

    // Test 6: reset with level=3 and an edge present in the reset cycle
    Z1 = 1'b1; reset = 1'b0; tick();
    chk("r_valid", rd_valid, 0);
    chk("r_kind", rd_kind, 0);
    chk("r_ts", rd_ts, 0);
    chk("r_z1", z1_count, 0);
    chk("r_z2", z2_count, 0);
    chk("r_level", level, 0);
    chk("r_ovf", overflow, 0);
    // Z1 still high after release logs as a new edge at ts=0
    reset = 1'b1; cyc = 0; tick();
    chk("rp_valid", rd_valid, 1);
    chk("rp_kind", rd_kind, 2'b01);
    chk("rp_ts", rd_ts, 0);
    chk("rp_z1", z1_count, 1);
    tick();
    chk("rp_held_level", level, 1);
    Z1 = 1'b0;

`ifdef LOGGER_CLEAR_EN
    // Test 7: clr with level=2, z1_count=2
    tick();
    Z1 = 1'b1; tick(); Z1 = 1'b0;
    chk("c_pre_level", level, 2);
    chk("c_pre_z1", z1_count, 2);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("c_level", level, 0);
    chk("c_z1", z1_count, 0);
    chk("c_ovf", overflow, 0);
    chk("c_valid", rd_valid, 0);
    Z1 = 1'b1; tick(); Z1 = 1'b0;
    chk("c_ts_restart", rd_ts, 0);
    chk("c_post_z1", z1_count, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
